// File: rtl/banked_port_pkg.sv
// rtl/banked_port_pkg.sv - shared arbitration constants and width helper for the banked port arbiter
package banked_port_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int calc_bw(input int num_banks);
        return $clog2(num_banks);
    endfunction

endpackage

// File: rtl/bank_onehot_decoder.sv
// rtl/bank_onehot_decoder.sv - binary bank index to one-hot bank enable
module bank_onehot_decoder #(
    parameter int NUM_BANKS = 4,
    parameter int BW        = 2
) (
    input  logic [BW-1:0]        bank_idx,
    output logic [NUM_BANKS-1:0] onehot
);

    always_comb begin
        onehot           = '0;
        onehot[bank_idx] = 1'b1;
    end

endmodule

// File: rtl/banked_port_arbiter.sv
// rtl/banked_port_arbiter.sv - two-port arbiter into banked memory with collision detection and counting
module banked_port_arbiter
    import banked_port_pkg::*;
#(
    parameter int    MEM_DEPTH    = 64,
    parameter int    NUM_BANKS    = 4,
    parameter int    DATA_WIDTH   = 8,
    parameter int    PARITY_BITS  = $clog2(DATA_WIDTH) + 1,
    parameter int    ENCODED_WORD = DATA_WIDTH + PARITY_BITS,
    parameter int    ARB_MODE     = 0,
    localparam int   CW           = ENCODED_WORD + 1,
    localparam int   BW           = calc_bw(NUM_BANKS),
    localparam int   BAW          = $clog2(MEM_DEPTH),
    localparam int   AW           = BW + BAW
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_a,
    input  logic                 i_req_b,
    input  logic                 i_we_a,
    input  logic                 i_we_b,
    input  logic [AW-1:0]        i_addr_a,
    input  logic [AW-1:0]        i_addr_b,
    input  logic [CW-1:0]        i_data_a,
    input  logic [CW-1:0]        i_data_b,
    output logic                 o_rdy_a,
    output logic                 o_rdy_b,
    output logic [NUM_BANKS-1:0] o_bank_en_a,
    output logic [NUM_BANKS-1:0] o_bank_en_b,
    output logic                 o_bank_we_a,
    output logic                 o_bank_we_b,
    output logic [BAW-1:0]       o_bank_addr_a,
    output logic [BAW-1:0]       o_bank_addr_b,
    output logic [CW-1:0]        o_bank_data_a,
    output logic [CW-1:0]        o_bank_data_b,
    output logic                 o_conflict,
    output logic [15:0]          o_conflict_cnt
);

    logic [NUM_BANKS-1:0] onehot_a;
    logic [NUM_BANKS-1:0] onehot_b;
    logic                 collision;
    logic                 tie_to_b;
    logic                 xfer_a;
    logic                 xfer_b;
    // Holds the port owed the next tie (0=A): the loser of the previous one.
    logic                 last_winner;

    bank_onehot_decoder #(.NUM_BANKS(NUM_BANKS), .BW(BW)) u_dec_a (
        .bank_idx (i_addr_a[AW-1 -: BW]),
        .onehot   (onehot_a)
    );

    bank_onehot_decoder #(.NUM_BANKS(NUM_BANKS), .BW(BW)) u_dec_b (
        .bank_idx (i_addr_b[AW-1 -: BW]),
        .onehot   (onehot_b)
    );

    // Full address equality covers both same bank and same in-bank word.
    assign collision = i_req_a && i_req_b && (i_addr_a == i_addr_b) && (i_we_a || i_we_b);
    assign tie_to_b  = (ARB_MODE == ARB_RR) && last_winner;
    assign o_rdy_a   = i_req_a && !(collision && tie_to_b);
    assign o_rdy_b   = i_req_b && !(collision && !tie_to_b);
    assign xfer_a    = i_req_a && o_rdy_a;
    assign xfer_b    = i_req_b && o_rdy_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bank_en_a    <= '0;
            o_bank_en_b    <= '0;
            o_bank_we_a    <= 1'b0;
            o_bank_we_b    <= 1'b0;
            o_bank_addr_a  <= '0;
            o_bank_addr_b  <= '0;
            o_bank_data_a  <= '0;
            o_bank_data_b  <= '0;
            o_conflict     <= 1'b0;
            o_conflict_cnt <= '0;
            last_winner    <= 1'b0;
        end else begin
            o_bank_en_a <= xfer_a ? onehot_a : '0;
            o_bank_en_b <= xfer_b ? onehot_b : '0;
            o_bank_we_a <= xfer_a && i_we_a;
            o_bank_we_b <= xfer_b && i_we_b;
            if (xfer_a) begin
                o_bank_addr_a <= i_addr_a[BAW-1:0];
                o_bank_data_a <= i_data_a;
            end
            if (xfer_b) begin
                o_bank_addr_b <= i_addr_b[BAW-1:0];
                o_bank_data_b <= i_data_b;
            end
            o_conflict <= collision;
            if (collision) begin
                last_winner <= !tie_to_b;
                if (o_conflict_cnt != 16'hFFFF) begin
                    o_conflict_cnt <= o_conflict_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_banked_port_arbiter.sv
// tb/tb_banked_port_arbiter.sv - randomized and directed bench for both arbitration modes of banked_port_arbiter
module tb_banked_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, we_a, we_b;
    logic [7:0]  addr_a, addr_b;
    logic [12:0] data_a, data_b;

    logic [1:0]  rdy_a, rdy_b, we_oa, we_ob, conf;
    logic [3:0]  en_a [2];
    logic [3:0]  en_b [2];
    logic [5:0]  ad_a [2];
    logic [5:0]  ad_b [2];
    logic [12:0] da_a [2];
    logic [12:0] da_b [2];
    logic [15:0] cnt  [2];

    int total = 0;
    int bad   = 0;

    // Reference state, one slot per arbitration mode
    logic [3:0]  e_en_a [2];
    logic [3:0]  e_en_b [2];
    bit          e_we_a [2];
    bit          e_we_b [2];
    logic [5:0]  e_ad_a [2];
    logic [5:0]  e_ad_b [2];
    logic [12:0] e_da_a [2];
    logic [12:0] e_da_b [2];
    bit          e_conf [2];
    int          e_cnt  [2];
    bit          owed_b [2];

    always #5 clk = ~clk;

    banked_port_arbiter #(.ARB_MODE(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_a(req_a), .i_req_b(req_b), .i_we_a(we_a), .i_we_b(we_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b), .i_data_a(data_a), .i_data_b(data_b),
        .o_rdy_a(rdy_a[0]), .o_rdy_b(rdy_b[0]),
        .o_bank_en_a(en_a[0]), .o_bank_en_b(en_b[0]),
        .o_bank_we_a(we_oa[0]), .o_bank_we_b(we_ob[0]),
        .o_bank_addr_a(ad_a[0]), .o_bank_addr_b(ad_b[0]),
        .o_bank_data_a(da_a[0]), .o_bank_data_b(da_b[0]),
        .o_conflict(conf[0]), .o_conflict_cnt(cnt[0])
    );

    banked_port_arbiter #(.ARB_MODE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_a(req_a), .i_req_b(req_b), .i_we_a(we_a), .i_we_b(we_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b), .i_data_a(data_a), .i_data_b(data_b),
        .o_rdy_a(rdy_a[1]), .o_rdy_b(rdy_b[1]),
        .o_bank_en_a(en_a[1]), .o_bank_en_b(en_b[1]),
        .o_bank_we_a(we_oa[1]), .o_bank_we_b(we_ob[1]),
        .o_bank_addr_a(ad_a[1]), .o_bank_addr_b(ad_b[1]),
        .o_bank_data_a(da_a[1]), .o_bank_data_b(da_b[1]),
        .o_conflict(conf[1]), .o_conflict_cnt(cnt[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            e_en_a[m] = '0; e_en_b[m] = '0; e_we_a[m] = 0; e_we_b[m] = 0;
            e_ad_a[m] = '0; e_ad_b[m] = '0; e_da_a[m] = '0; e_da_b[m] = '0;
            e_conf[m] = 0;  e_cnt[m]  = 0;  owed_b[m] = 0;
        end
    endtask

    task automatic check_regs();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_en_a", m), 32'(en_a[m]), 32'(e_en_a[m]));
            check($sformatf("m%0d_en_b", m), 32'(en_b[m]), 32'(e_en_b[m]));
            check($sformatf("m%0d_we_a", m), 32'(we_oa[m]), 32'(e_we_a[m]));
            check($sformatf("m%0d_we_b", m), 32'(we_ob[m]), 32'(e_we_b[m]));
            check($sformatf("m%0d_addr_a", m), 32'(ad_a[m]), 32'(e_ad_a[m]));
            check($sformatf("m%0d_addr_b", m), 32'(ad_b[m]), 32'(e_ad_b[m]));
            check($sformatf("m%0d_data_a", m), 32'(da_a[m]), 32'(e_da_a[m]));
            check($sformatf("m%0d_data_b", m), 32'(da_b[m]), 32'(e_da_b[m]));
            check($sformatf("m%0d_conflict", m), 32'(conf[m]), 32'(e_conf[m]));
            check($sformatf("m%0d_cnt", m), 32'(cnt[m]), 32'(e_cnt[m]));
        end
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    task automatic cycle();
        bit col, ga, gb;
        #4;
        col = req_a && req_b && (addr_a == addr_b) && (we_a || we_b);
        for (int m = 0; m < 2; m++) begin
            if (!col) begin
                ga = req_a; gb = req_b;
            end else if (m == 0) begin
                ga = 1; gb = 0;
            end else begin
                gb = owed_b[m]; ga = !gb;
            end
            if (rst_n) begin
                check($sformatf("m%0d_rdy_a", m), 32'(rdy_a[m]), 32'(ga));
                check($sformatf("m%0d_rdy_b", m), 32'(rdy_b[m]), 32'(gb));
                e_en_a[m] = ga ? (4'b0001 << addr_a[7:6]) : 4'b0000;
                e_en_b[m] = gb ? (4'b0001 << addr_b[7:6]) : 4'b0000;
                e_we_a[m] = ga && we_a;
                e_we_b[m] = gb && we_b;
                if (ga) begin e_ad_a[m] = addr_a[5:0]; e_da_a[m] = data_a; end
                if (gb) begin e_ad_b[m] = addr_b[5:0]; e_da_b[m] = data_b; end
                e_conf[m] = col;
                if (col) begin
                    if (e_cnt[m] < 65535) e_cnt[m]++;
                    owed_b[m] = ga;
                end
            end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic drive(input bit ra, input bit wa, input logic [7:0] aa, input logic [12:0] dta,
                         input bit rb, input bit wb, input logic [7:0] ab, input logic [12:0] dtb);
        req_a = ra; we_a = wa; addr_a = aa; data_a = dta;
        req_b = rb; we_b = wb; addr_b = ab; data_b = dtb;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pool [4];
        pool[0] = 8'h10; pool[1] = 8'h45; pool[2] = 8'hC3; pool[3] = 8'h20;
        rst_n = 1'b1;
        drive(0, 0, 8'h00, 13'h0, 0, 0, 8'h00, 13'h0);
        #1;
        do_reset();

        drive(1, 1, 8'h45, 13'h0AB, 0, 0, 8'h00, 13'h0);
        cycle();
        check("write_a_en", 32'(en_a[0]), 32'h2);
        check("write_a_addr", 32'(ad_a[0]), 32'h05);
        check("write_a_data", 32'(da_a[0]), 32'h0AB);
        check("write_a_we", 32'(we_oa[0]), 32'h1);

        drive(1, 1, 8'hC3, 13'h111, 1, 0, 8'hC3, 13'h0);
        cycle();
        check("coll_fixed_conflict", 32'(conf[0]), 32'h1);
        check("coll_fixed_cnt", 32'(cnt[0]), 32'h1);
        drive(0, 0, 8'h00, 13'h0, 1, 0, 8'hC3, 13'h0);
        cycle();
        check("coll_fixed_b_later", 32'(en_b[0]), 32'h8);

        do_reset();
        drive(1, 1, 8'h10, 13'h0A1, 1, 1, 8'h10, 13'h0B2);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("rr_alt_%0d", i), 32'(we_ob[1]), 32'(i % 2));
        end
        check("rr_cnt4", 32'(cnt[1]), 32'h4);

        drive(1, 0, 8'h20, 13'h0, 1, 0, 8'h20, 13'h0);
        cycle();
        check("rr_read_both_a", 32'(en_a[0]), 32'h1);
        check("rr_read_both_b", 32'(en_b[1]), 32'h1);
        check("rr_read_noconf", 32'(conf[1]), 32'h0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), pool[$urandom_range(0, 3)], 13'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1), pool[$urandom_range(0, 3)], 13'($urandom));
            cycle();
        end

        // Reset asserted in the middle of a cycle with a transfer pending.
        drive(1, 1, 8'h45, 13'h1FF, 1, 1, 8'h45, 13'h0CC);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(posedge clk);
        #1;
        check_regs();
        rst_n = 1'b1;
        drive(1, 1, 8'h10, 13'h055, 1, 1, 8'h10, 13'h066);
        cycle();
        check("post_reset_cnt", 32'(cnt[1]), 32'h1);
        check("post_reset_a_wins", 32'(en_a[1]), 32'h1);

        for (int i = 0; i < 65540; i++) begin
            cycle();
        end
        check("sat_fixed", 32'(cnt[0]), 32'hFFFF);
        check("sat_rr", 32'(cnt[1]), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
